// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the MEM stage of the 16-bit pipeline.
package mem_stage_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 10;
    localparam int REG_AW     = 3;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/memory_stage_if.sv
// Execute-to-MEM request and MEM/WB result bundle.
interface memory_stage_if
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) ();

    // Handshake: the slave takes an instruction on a rising edge when in_valid is high,
    // stall is low and the slave is idle. While stall is high the master holds every
    // request field stable. In the cycle a memory op retires, stall is already low so
    // the master advances, but the slave ignores whatever is presented in that cycle.
    logic                  in_valid;
    logic                  mem_read;
    logic                  mem_write;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     store_data;
    logic [REG_AW-1:0]     write_address;
    logic                  write_back;
    logic                  stall;
    logic                  wb_valid;
    logic                  wb_write_back;
    logic [REG_AW-1:0]     wb_address;
    logic [DATA_W-1:0]     wb_data;

    modport master (
        output in_valid, mem_read, mem_write, alu_result, store_data,
               write_address, write_back,
        input  stall, wb_valid, wb_write_back, wb_address, wb_data
    );

    modport slave (
        input  in_valid, mem_read, mem_write, alu_result, store_data,
               write_address, write_back,
        output stall, wb_valid, wb_write_back, wb_address, wb_data
    );

endinterface

// File: rtl/memory_stage_data_mem.sv
// Single-port data RAM: synchronous write, combinational read so data is ready at retire.
module data_mem #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // Contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/memory_stage.sv
// MEM stage: multi-cycle loads/stores with upstream stall, registered MEM/WB buffer.
module memory_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int ACC_LAT = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    memory_stage_if.slave  bus,
    output state_e         dbg_state_o
);

    localparam int               CNT_W    = $clog2(ACC_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACC_LAT - 1);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   h_alu_q;
    logic [DATA_W-1:0]   h_sdata_q;
    logic [REG_AW-1:0]   h_wa_q;
    logic                h_wb_q;
    logic                h_store_q;
    logic                wb_valid_q;
    logic                wb_write_back_q;
    logic [REG_AW-1:0]   wb_address_q;
    logic [DATA_W-1:0]   wb_data_q;

    logic                mem_op;
    logic                retire;
    logic                mem_we;
    logic                stall_d;
    logic [DATA_W-1:0]   rd_data;

    assign mem_op = bus.in_valid & (bus.mem_read | bus.mem_write);
    assign retire = (state_q == WAIT) && (cnt_q == '0);
    assign mem_we = rst_n & retire & h_store_q;

    always_comb begin
        stall_d = 1'b0;
        if (rst_n) begin
            case (state_q)
                IDLE:    stall_d = mem_op;
                WAIT:    stall_d = (cnt_q != '0);
                default: stall_d = 1'b0;
            endcase
        end
    end

    data_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_data_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .addr_i  (h_alu_q[ADDR_W-1:0]),
        .wdata_i (h_sdata_q),
        .rdata_o (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            h_alu_q         <= '0;
            h_sdata_q       <= '0;
            h_wa_q          <= '0;
            h_wb_q          <= 1'b0;
            h_store_q       <= 1'b0;
            wb_valid_q      <= 1'b0;
            wb_write_back_q <= 1'b0;
            wb_address_q    <= '0;
            wb_data_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_op) begin
                        // Store wins when both read and write are asserted.
                        h_alu_q         <= bus.alu_result;
                        h_sdata_q       <= bus.store_data;
                        h_wa_q          <= bus.write_address;
                        h_wb_q          <= bus.write_back;
                        h_store_q       <= bus.mem_write;
                        cnt_q           <= CNT_INIT;
                        state_q         <= WAIT;
                        wb_valid_q      <= 1'b0;
                        wb_write_back_q <= 1'b0;
                    end else if (bus.in_valid) begin
                        wb_valid_q      <= 1'b1;
                        wb_write_back_q <= bus.write_back;
                        wb_address_q    <= bus.write_address;
                        wb_data_q       <= bus.alu_result;
                    end else begin
                        wb_valid_q      <= 1'b0;
                        wb_write_back_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q           <= cnt_q - 1'b1;
                        wb_valid_q      <= 1'b0;
                        wb_write_back_q <= 1'b0;
                    end else begin
                        wb_valid_q      <= 1'b1;
                        wb_write_back_q <= h_wb_q;
                        wb_address_q    <= h_wa_q;
                        wb_data_q       <= h_store_q ? h_alu_q : rd_data;
                        state_q         <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.stall         = stall_d;
    assign bus.wb_valid      = wb_valid_q;
    assign bus.wb_write_back = wb_write_back_q;
    assign bus.wb_address    = wb_address_q;
    assign bus.wb_data       = wb_data_q;
    assign dbg_state_o       = state_q;

endmodule
